// File: rtl/csr_regfile_pkg.sv
// Shared constants for the machine-mode CSR block: widths, CSR addresses,
// writable-bit masks and the decode of which addresses exist.
package csr_regfile_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] ZEROWORD = '0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  // MPP is hardwired to M-mode, so it always reads 2'b11.
  localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [XLEN-1:0] MIE_MASK      = 32'h0000_0888;
  localparam logic [XLEN-1:0] ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] MISA_VAL      = 32'h4000_0100;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Access bus between the CSR execution unit (master) and the CSR storage (slave).
interface csr_regfile_if;
  import csr_regfile_pkg::*;

  // ren/wen are single-cycle strobes with no ready: every access completes in
  // its own cycle, rdata/illegal are combinational and writes commit at the edge.
  logic [11:0]     csr_raddr;
  logic            csr_ren;
  logic [XLEN-1:0] csr_rdata;
  logic [11:0]     csr_waddr;
  logic            csr_wen;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_illegal;

  modport master (
    output csr_raddr, csr_ren, csr_waddr, csr_wen, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_raddr, csr_ren, csr_waddr, csr_wen, csr_wdata,
    output csr_rdata, csr_illegal
  );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter built from two XLEN halves; a half-write replaces that half
// and suppresses the increment for the cycle.
module csr_counter64
  import csr_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [2*XLEN-1:0] value_o
);

  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] hi_q, hi_d;

  always_comb begin
    {hi_d, lo_d} = {hi_q, lo_q} + {{(2*XLEN-1){1'b0}}, inc_i};
    if (wr_lo_i) begin
      lo_d = wdata_i;
      hi_d = hi_q;
    end else if (wr_hi_i) begin
      lo_d = lo_q;
      hi_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q <= ZEROWORD;
      hi_q <= ZEROWORD;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational reads, edge-committed writes,
// trap entry / mret updates and interrupt-pending generation.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [XLEN-1:0] HART_ID     = ZEROWORD,
  parameter logic [XLEN-1:0] MTVEC_RESET = ZEROWORD
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_regfile_if.slave    csr_bus,
  input  logic            instr_retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic            sw_irq,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rdata;
  logic [2*XLEN-1:0] mcycle, minstret;
  logic            wr_illegal;
  logic            wr_en;

  assign wr_illegal = csr_bus.csr_wen &
                      (~csr_implemented(csr_bus.csr_waddr) | (csr_bus.csr_waddr[11:10] == 2'b11));
  assign csr_bus.csr_illegal = (csr_bus.csr_ren & ~csr_implemented(csr_bus.csr_raddr)) | wr_illegal;
  // A trap in the same cycle swallows whatever the CSR unit was writing.
  assign wr_en = csr_bus.csr_wen & ~wr_illegal & ~trap_valid;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mepc_d     = trap_pc & ALIGN_MASK;
      mcause_d   = trap_cause;
      mtval_d    = trap_tval;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = DISABLE;
    end else begin
      if (mret) begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = ENABLE;
      end
      if (wr_en) begin
        case (csr_bus.csr_waddr)
          CSR_MSTATUS: if (!mret) begin
            mst_mie_d  = csr_bus.csr_wdata[MSTATUS_MIE];
            mst_mpie_d = csr_bus.csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_d      = csr_bus.csr_wdata & MIE_MASK;
          CSR_MTVEC:    mtvec_d    = csr_bus.csr_wdata & ALIGN_MASK;
          CSR_MSCRATCH: mscratch_d = csr_bus.csr_wdata;
          CSR_MEPC:     mepc_d     = csr_bus.csr_wdata & ALIGN_MASK;
          CSR_MCAUSE:   mcause_d   = csr_bus.csr_wdata;
          CSR_MTVAL:    mtval_d    = csr_bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mip_d           = ZEROWORD;
    mip_d[MIP_MSIP] = sw_irq;
    mip_d[MIP_MTIP] = timer_irq;
    mip_d[MIP_MEIP] = ext_irq;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mst_mie_q  <= DISABLE;
      mst_mpie_q <= DISABLE;
      mie_q      <= ZEROWORD;
      mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q <= ZEROWORD;
      mepc_q     <= ZEROWORD;
      mcause_q   <= ZEROWORD;
      mtval_q    <= ZEROWORD;
      mip_q      <= ZEROWORD;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ENABLE),
    .wr_lo_i (wr_en && (csr_bus.csr_waddr == CSR_MCYCLE)),
    .wr_hi_i (wr_en && (csr_bus.csr_waddr == CSR_MCYCLEH)),
    .wdata_i (csr_bus.csr_wdata),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instr_retire),
    .wr_lo_i (wr_en && (csr_bus.csr_waddr == CSR_MINSTRET)),
    .wr_hi_i (wr_en && (csr_bus.csr_waddr == CSR_MINSTRETH)),
    .wdata_i (csr_bus.csr_wdata),
    .value_o (minstret)
  );

  always_comb begin
    mstatus_rd               = MSTATUS_FIXED;
    mstatus_rd[MSTATUS_MIE]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
  end

  always_comb begin
    rdata = ZEROWORD;
    case (csr_bus.csr_raddr)
      CSR_MSTATUS:   rdata = mstatus_rd;
      CSR_MISA:      rdata = MISA_VAL;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       rdata = mip_q;
      CSR_MCYCLE:    rdata = mcycle[XLEN-1:0];
      CSR_MCYCLEH:   rdata = mcycle[2*XLEN-1:XLEN];
      CSR_MINSTRET:  rdata = minstret[XLEN-1:0];
      CSR_MINSTRETH: rdata = minstret[2*XLEN-1:XLEN];
      CSR_MHARTID:   rdata = HART_ID;
      default:       rdata = ZEROWORD;
    endcase
  end

  assign csr_bus.csr_rdata = rdata;
  assign mtvec_o           = mtvec_q;
  assign mepc_o            = mepc_q;
  assign irq_pending_o     = mst_mie_q & (|(mie_q & mip_q));

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed scenarios plus random traffic, checked
// against an architectural model through an expected-response queue.
module tb_csr_regfile;

  localparam logic [31:0] TB_HART_ID     = 32'd5;
  localparam logic [31:0] TB_MTVEC_RESET = 32'h8000_0100;

  typedef struct packed {
    logic        rst_n;
    logic        ren;
    logic [11:0] ra;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic        mret;
    logic        retire;
  } stim_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        ill;
    logic        irq;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic clk;
  logic rst_n;
  logic instr_retire, trap_valid, mret, ext_irq, timer_irq, sw_irq;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic [31:0] mtvec_o, mepc_o;
  logic irq_pending_o;
  logic [2:0] irq_lvl;  // {ext, timer, sw}

  csr_regfile_if bus();

  csr_regfile #(.HART_ID(TB_HART_ID), .MTVEC_RESET(TB_MTVEC_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .csr_bus(bus),
    .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // architectural model
  bit          model_valid = 0;
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_pool [23] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
                                  12'h000, 12'h7C0, 12'h345, 12'hB01, 12'h302, 12'h3A0};

  function automatic bit m_impl(input logic [11:0] a);
    foreach (addr_pool[i]) if (i < 17 && addr_pool[i] == a) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return TB_HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t m_expect(input stim_t s);
    exp_t e;
    e.addr  = s.ra;
    e.rdata = m_read(s.ra);
    e.ill   = (s.ren && !m_impl(s.ra)) || (s.we && (!m_impl(s.wa) || s.wa[11:10] == 2'b11));
    e.irq   = m_mstatus[3] && ((m_mie & m_mip) != 32'h0);
    e.mtvec = m_mtvec;
    e.mepc  = m_mepc;
    return e;
  endfunction

  function automatic void m_step(input stim_t s);
    logic [63:0] nc, ni;
    bit wr_ok;
    if (!s.rst_n) begin
      m_mstatus = 32'h1800; m_mie = 0; m_mtvec = TB_MTVEC_RESET & ~32'h3;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0;
      m_cycle = 0; m_instret = 0; model_valid = 1;
      return;
    end
    nc = m_cycle + 64'd1;
    ni = m_instret + (s.retire ? 64'd1 : 64'd0);
    wr_ok = s.we && m_impl(s.wa) && (s.wa[11:10] != 2'b11) && !s.trap;
    if (s.trap) begin
      m_mepc = s.pc & ~32'h3; m_mcause = s.cause; m_mtval = s.tval;
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (s.mret) begin
      m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end
    if (wr_ok) begin
      case (s.wa)
        12'h300: if (!s.mret) m_mstatus = 32'h1800 | (s.wd & 32'h88);
        12'h304: m_mie = s.wd & 32'h888;
        12'h305: m_mtvec = s.wd & ~32'h3;
        12'h340: m_mscratch = s.wd;
        12'h341: m_mepc = s.wd & ~32'h3;
        12'h342: m_mcause = s.wd;
        12'h343: m_mtval = s.wd;
        12'hB00: nc = {m_cycle[63:32], s.wd};
        12'hB80: nc = {s.wd, m_cycle[31:0]};
        12'hB02: ni = {m_instret[63:32], s.wd};
        12'hB82: ni = {s.wd, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = nc;
    m_instret = ni;
    m_mip = (irq_lvl[2] ? 32'h800 : 32'h0) | (irq_lvl[1] ? 32'h80 : 32'h0) |
            (irq_lvl[0] ? 32'h8 : 32'h0);
  endfunction

  // driver tasks
  function automatic stim_t rd(input logic [11:0] a);
    stim_t s = '0;
    s.rst_n = 1'b1; s.ren = 1'b1; s.ra = a;
    return s;
  endfunction

  function automatic stim_t wr(input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra);
    stim_t s = rd(ra);
    s.we = 1'b1; s.wa = wa; s.wd = wd;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bit issue;
    issue = s.ren && model_valid;
    rst_n = s.rst_n;
    bus.csr_raddr = s.ra; bus.csr_ren = issue;
    bus.csr_waddr = s.wa; bus.csr_wen = s.we; bus.csr_wdata = s.wd;
    trap_valid = s.trap; trap_cause = s.cause; trap_pc = s.pc; trap_tval = s.tval;
    mret = s.mret; instr_retire = s.retire;
    {ext_irq, timer_irq, sw_irq} = irq_lvl;
    if (issue) exp_q.push_back(m_expect(s));
    @(posedge clk);
    m_step(s);
    #1;
  endtask

  task automatic read_all();
    foreach (addr_pool[i]) drive(rd(addr_pool[i]));
  endtask

  // scoreboard monitor
  task automatic check(input string name, input logic [11:0] a, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s addr=0x%03h got=0x%08h exp=0x%08h t=%0t", name, a, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.csr_ren === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response t=%0t", $time);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("rdata",       e.addr, bus.csr_rdata,            e.rdata);
          check("csr_illegal", e.addr, {31'b0, bus.csr_illegal}, {31'b0, e.ill});
          check("irq_pending", e.addr, {31'b0, irq_pending_o},   {31'b0, e.irq});
          check("mtvec_o",     e.addr, mtvec_o,                  e.mtvec);
          check("mepc_o",      e.addr, mepc_o,                   e.mepc);
        end
      end
    end
  end

  // stimulus
  initial begin : stimulus
    stim_t s;
    irq_lvl = 3'b000;
    s = rd(12'h300); s.rst_n = 1'b0;
    drive(s);
    drive(s);
    read_all();

    drive(wr(12'h304, 32'hFFFF_FFFF, 12'h304));
    drive(rd(12'h304));
    drive(wr(12'h341, 32'hFFFF_FFFF, 12'h341));
    drive(rd(12'h341));
    drive(wr(12'hF14, 32'h1234_5678, 12'hF14));
    drive(rd(12'hF14));
    drive(rd(12'h7C0));
    drive(wr(12'h301, 32'h0, 12'h301));
    drive(wr(12'h344, 32'hFFFF_FFFF, 12'h344));

    // interrupt pending, then trap with a colliding mscratch write
    drive(wr(12'h304, 32'h0000_0080, 12'h304));
    drive(wr(12'h300, 32'h0000_0008, 12'h300));
    irq_lvl = 3'b010;
    drive(rd(12'h344));
    drive(rd(12'h344));
    s = wr(12'h340, 32'hDEAD_BEEF, 12'h340);
    s.trap = 1'b1; s.pc = 32'h8000_0102; s.cause = 32'h8000_0007; s.tval = 32'h0000_0bad;
    drive(s);
    drive(rd(12'h341)); drive(rd(12'h342)); drive(rd(12'h343));
    drive(rd(12'h300)); drive(rd(12'h340));

    s = rd(12'h300); s.mret = 1'b1;
    drive(s);
    drive(rd(12'h300));
    drive(wr(12'h300, 32'h0, 12'h300));
    s = wr(12'h300, 32'h0, 12'h300); s.mret = 1'b1;
    drive(s);
    drive(rd(12'h300));
    s = wr(12'h340, 32'h0BAD_F00D, 12'h340); s.mret = 1'b1;
    drive(s);
    drive(rd(12'h340));
    irq_lvl = 3'b000;

    // counter carry and retire counting
    drive(wr(12'hB00, 32'hFFFF_FFFE, 12'hB00));
    drive(rd(12'hB00));
    drive(rd(12'hB80));
    drive(rd(12'hB00));
    drive(wr(12'hB82, 32'h0000_0007, 12'hB82));
    for (int i = 0; i < 5; i++) begin
      s = rd(12'hB02); s.retire = 1'b1;
      drive(s);
    end
    drive(rd(12'hB02));
    drive(rd(12'hB82));

    // reset colliding with a trap
    drive(wr(12'h340, 32'h5555_AAAA, 12'h340));
    s = wr(12'h343, 32'h1, 12'h341); s.rst_n = 1'b0; s.trap = 1'b1;
    s.pc = 32'h1000_0004; s.cause = 32'h2;
    drive(s);
    read_all();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      s = rd(addr_pool[$urandom_range(0, 22)]);
      s.rst_n  = ($urandom_range(0, 199) != 0);
      s.we     = ($urandom_range(0, 2) == 0);
      s.wa     = addr_pool[$urandom_range(0, 22)];
      s.wd     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      s.trap   = ($urandom_range(0, 15) == 0);
      s.cause  = $urandom;
      s.pc     = $urandom;
      s.tval   = $urandom;
      s.mret   = ($urandom_range(0, 11) == 0);
      s.retire = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) irq_lvl = 3'($urandom_range(0, 7));
      drive(s);
    end

    s = rd(12'h300); s.ren = 1'b0;
    drive(s);
    drive(s);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR storage for the RV32 core: the responder behind the CSR execution unit. Holds the machine trap-setup and trap-handling registers, the 64-bit cycle and retired-instruction counters, and the read-only ID registers.
- Returns `csr_rdata` combinationally for the unit to merge, and commits its `csr_wen`/`csr_wdata` on the clock edge.
- Applies trap entry and `mret` updates, and raises `irq_pending_o` to the pipeline.

## Interface
Parameters:
- `HART_ID`, default 0: value returned by `mhartid`.
- `MTVEC_RESET`, default `XLEN'h0000_0000`: reset value of `mtvec`.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `csr_raddr` in 12: read address (instruction imm[11:0]).
- `csr_ren` in 1: read strobe; only gates `csr_illegal`.
- `csr_rdata` out `XLEN`: combinational read of the current (pre-edge) value.
- `csr_waddr` in 12: write address.
- `csr_wen` in 1: write enable from the CSR unit.
- `csr_wdata` in `XLEN`: final write value (already merged for set/clear).
- `csr_illegal` out 1: combinational illegal-access flag.
- `instr_retire` in 1: one instruction retired this cycle.
- `trap_valid` in 1: trap entry this cycle.
- `trap_cause` in `XLEN`: cause value for the trap.
- `trap_pc` in `XLEN`: PC of the trapping instruction.
- `trap_tval` in `XLEN`: trap value.
- `mret` in 1: `mret` executed this cycle.
- `ext_irq` in 1, `timer_irq` in 1, `sw_irq` in 1: raw interrupt lines, level-sensitive.
- `mtvec_o` out `XLEN`: registered `mtvec` value.
- `mepc_o` out `XLEN`: registered `mepc` value.
- `irq_pending_o` out 1: `mstatus.MIE & |(mie & mip)`.

## Operation
Register map (address, reset value):
- `mstatus` 0x300, 0x0000_1800: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
- `misa` 0x301, 0x4000_0100: RV32I; writes are accepted and ignored (WARL).
- `mie` 0x304, 0: only bits 3, 7 and 11 are writable.
- `mtvec` 0x305, `MTVEC_RESET`: direct mode only; bits [1:0] read 0.
- `mscratch` 0x340, 0: full width.
- `mepc` 0x341, 0: bits [1:0] forced to 0.
- `mcause` 0x342, 0: full width.
- `mtval` 0x343, 0: full width.
- `mip` 0x344, 0: read-only; MSIP[3], MTIP[7] and MEIP[11] are registered one cycle from `sw_irq`, `timer_irq` and `ext_irq`. A write is ignored and is not flagged as illegal.
- `mcycle` 0xB00 / `mcycleh` 0xB80: 64-bit counter, +1 every cycle out of reset.
- `minstret` 0xB02 / `minstreth` 0xB82: 64-bit counter, +1 when `instr_retire`.
- `mvendorid` 0xF11, `marchid` 0xF12, `mimpid` 0xF13: read 0.
- `mhartid` 0xF14: reads `HART_ID`.

Illegal access:
- `csr_illegal` = (`csr_ren` & unimplemented `csr_raddr`) | (`csr_wen` & (unimplemented `csr_waddr` | `csr_waddr[11:10]` == 2'b11)).
- An illegal write changes no state.
- Reads of unimplemented addresses return `ZEROWORD`.

Same-cycle priority: `trap_valid` > `mret` > CSR write.
- Trap entry:
  - `mepc` <= `trap_pc` & ~3.
  - `mcause` <= `trap_cause`.
  - `mtval` <= `trap_tval`.
  - MPIE <= MIE; MIE <= 0.
  - A concurrent `csr_wen` is dropped.
- `mret`: MIE <= MPIE; MPIE <= 1. A concurrent write to `mstatus` is dropped; writes to other CSRs still commit.
- Counter write vs increment: the written half loads `csr_wdata` and that counter does not increment this cycle; the other half holds.
- Counter carry: the low half wraps 0xFFFF_FFFF → 0 and increments the high half in the same edge. The 64-bit value wraps to 0.

## Timing
- Read: zero latency, combinational from the address. A write at edge N is visible on `csr_rdata` after edge N.
- Read and write to the same address in one cycle: `csr_rdata` returns the old value.
- Reset: every register takes its listed reset value, both counters go to 0 and `mip` goes to 0, at the first edge with `rst_n`=0.
  - Consequences: `irq_pending_o`=0, `mtvec_o`=`MTVEC_RESET`, `mepc_o`=0.
  - Reset overrides any concurrent trap, `mret` or write.
- `irq_pending_o` responds 1 cycle after an interrupt line rises (`mip` register) and is combinational on `mie`/`mstatus`.
- `mtvec_o` and `mepc_o` are valid the cycle after a write or trap.

## Structure
- Add to `defines.v`:
  - CSR addresses (`CSR_MSTATUS` …), writable-bit masks, bit positions (`MSTATUS_MIE`=3, `MSTATUS_MPIE`=7) and `MISA_VAL`.
  - Reuse `XLEN`, `ZEROWORD`, `ENABLE`/`DISABLE`.
- Sub-module `csr_counter64`: 64-bit counter with an increment enable and two half-write ports (low/high load, with carry). Instantiated twice, for `mcycle` and `minstret`.

## Test plan
- Reset then read each address: `mstatus`=0x1800, `misa`=0x4000_0100, `mhartid`=`HART_ID`, all others 0, `csr_illegal`=0 for implemented addresses.
- Write 0xFFFF_FFFF to `mie` → reads 0x888. Write 0xFFFF_FFFF to `mepc` → reads 0xFFFF_FFFC. Write to 0xF14 → `csr_illegal`=1 and the value is unchanged. Read 0x7C0 → `csr_illegal`=1 and `rdata`=0.
- With `mstatus`=0x1808, `mie`=0x80, raise `timer_irq` → `irq_pending_o`=1 one cycle later. Then trap with `trap_pc`=0x8000_0102 and `trap_cause`=0x8000_0007, plus a concurrent write to `mscratch`:
  - `mepc`=0x8000_0100, `mcause`=0x8000_0007, `mstatus`=0x1880.
  - `irq_pending_o`=0; `mscratch` unchanged.
- `mret` from that state → `mstatus`=0x1888. `mret` concurrent with a write of 0 to `mstatus` → the `mret` result wins.
- Write `mcycle`=0xFFFF_FFFE → after 2 more edges `mcycle`=0 and `mcycleh`=1. Hold `instr_retire`=1 for 5 cycles → `minstret`=5.
- Assert `rst_n`=0 mid-trap (with `trap_valid`=1) → all registers at reset values after that edge, `irq_pending_o`=0.
